pn_packet_encoder: RTL and testbench

PN_PACKET_ENCODER -- requirements
Module: pn_packet_encoder

---
 rtl/pn_packet_encoder.sv | 163 ++++++++++++++++
 tb/tb_pn_packet_encoder.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pn_packet_encoder.sv
// Packs neuron spike IDs (pairs, lone, rich) and parameter writes into iADDR/W_DATA packets; one cycle decision-to-o_valid.
// Output holds while o_ready is low; spikes queue in a FIFO and stall only when it is full; parameters wait only while a packet is out.
module pn_packet_encoder #(
    parameter int FIFO_DEPTH   = 8,
    parameter int PAIR_TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        spk_valid,
    input  logic [6:0]                  spk_id,
    input  logic                        spk_rich,
    output logic                        spk_ready,
    input  logic                        prm_valid,
    input  logic [1:0]                  prm_tgt,
    input  logic [6:0]                  prm_addr,
    input  logic [31:0]                 prm_data,
    output logic                        prm_ready,
    input  logic                        flush,
    output logic                        o_valid,
    input  logic                        o_ready,
    output logic [15:0]                 o_addr,
    output logic [31:0]                 o_data,
    output logic                        err_tgt,
    output logic [$clog2(FIFO_DEPTH):0] fifo_cnt
);
    localparam int         PW       = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL_CNT = FIFO_DEPTH[PW:0];
    localparam int         TO_M1    = PAIR_TIMEOUT - 1;
    localparam logic [7:0] TO_LAST  = TO_M1[7:0];
    localparam logic [6:0] NULL_ID  = 7'h7F;

    typedef enum logic [1:0] {IDLE, HOLD, OUT} state_t;
    typedef struct packed {
        logic       rich;
        logic [6:0] id;
    } spk_t;

    state_t        state, state_nxt;
    spk_t          mem [FIFO_DEPTH];
    spk_t          head;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          push, pop, head_vld;

    logic          hold_vld;
    logic [6:0]    hold_id;
    logic [7:0]    timer;
    logic          take_a, drop_a, load_out, prm_acc, prm_bad;
    logic [15:0]   addr_nxt;
    logic [31:0]   data_nxt;

    assign spk_ready = (fifo_cnt != FULL_CNT);
    assign push      = spk_valid && spk_ready && (spk_id != NULL_ID);
    assign head      = mem[rd_ptr];
    assign head_vld  = (fifo_cnt != '0);
    assign o_valid   = (state == OUT);
    // Gated by reset so a parameter offered during reset is never reported as taken.
    assign prm_ready = prm_acc && rst;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        take_a    = 1'b0;
        drop_a    = 1'b0;
        load_out  = 1'b0;
        prm_acc   = 1'b0;
        prm_bad   = 1'b0;
        addr_nxt  = o_addr;
        data_nxt  = o_data;
        case (state)
            IDLE, HOLD: begin
                if (prm_valid) begin
                    prm_acc = 1'b1;
                    if (prm_tgt == 2'b00) begin
                        prm_bad = 1'b1;
                    end else begin
                        load_out  = 1'b1;
                        addr_nxt  = {1'b1, prm_tgt, 6'b0, prm_addr};
                        data_nxt  = prm_data;
                        state_nxt = OUT;
                    end
                end else if (state == IDLE) begin
                    if (head_vld && head.rich) begin
                        pop       = 1'b1;
                        load_out  = 1'b1;
                        addr_nxt  = {1'b0, 2'b00, 1'b1, 5'b0, head.id};
                        data_nxt  = '0;
                        state_nxt = OUT;
                    end else if (head_vld) begin
                        pop       = 1'b1;
                        take_a    = 1'b1;
                        state_nxt = HOLD;
                    end
                end else if (head_vld && !head.rich) begin
                    pop       = 1'b1;
                    drop_a    = 1'b1;
                    load_out  = 1'b1;
                    addr_nxt  = {1'b0, hold_id[6:5], 1'b0, hold_id[4:0], head.id};
                    data_nxt  = '0;
                    state_nxt = OUT;
                end else if (head_vld || flush || (timer >= TO_LAST)) begin
                    // A rich head is left queued; it goes out from IDLE after the lone packet.
                    drop_a    = 1'b1;
                    load_out  = 1'b1;
                    addr_nxt  = {1'b0, hold_id[6:5], 1'b0, hold_id[4:0], NULL_ID};
                    data_nxt  = '0;
                    state_nxt = OUT;
                end
            end
            OUT: begin
                if (o_ready) begin
                    state_nxt = hold_vld ? HOLD : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            hold_vld <= 1'b0;
            hold_id  <= '0;
            timer    <= '0;
            o_addr   <= '0;
            o_data   <= '0;
            err_tgt  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (take_a) begin
                hold_vld <= 1'b1;
                hold_id  <= head.id;
            end else if (drop_a) begin
                hold_vld <= 1'b0;
                hold_id  <= '0;
            end
            // Keeps running while a parameter packet is out; saturates so a long stall cannot wrap it.
            if (take_a) begin
                timer <= '0;
            end else if (hold_vld && (timer != 8'hFF)) begin
                timer <= timer + 1'b1;
            end
            if (load_out) begin
                o_addr <= addr_nxt;
                o_data <= data_nxt;
            end
            if (prm_bad) err_tgt <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{rich: spk_rich, id: spk_id};
    end
endmodule

// File: tb/tb_pn_packet_encoder.sv
// Randomised and directed bench for pn_packet_encoder against a packet-stream reference model.
module tb_pn_packet_encoder;
    localparam int DEPTH = 8;
    localparam int PT    = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spk_valid = 1'b0;
    logic [6:0]  spk_id = '0;
    logic        spk_rich = 1'b0;
    logic        spk_ready;
    logic        prm_valid = 1'b0;
    logic [1:0]  prm_tgt = '0;
    logic [6:0]  prm_addr = '0;
    logic [31:0] prm_data = '0;
    logic        prm_ready;
    logic        flush = 1'b0;
    logic        o_valid;
    logic        o_ready = 1'b0;
    logic [15:0] o_addr;
    logic [31:0] o_data;
    logic        err_tgt;
    logic [$clog2(DEPTH):0] fifo_cnt;

    int vec = 0;
    int bad = 0;
    logic        rdy_rand = 1'b0;
    logic        rdy_val  = 1'b0;
    logic [47:0] got[$];
    logic [47:0] exp_q[$];
    logic [6:0]  sp_id[$];
    logic        sp_rich[$];

    pn_packet_encoder #(.FIFO_DEPTH(DEPTH), .PAIR_TIMEOUT(PT)) dut (
        .clk(clk), .rst(rst),
        .spk_valid(spk_valid), .spk_id(spk_id), .spk_rich(spk_rich), .spk_ready(spk_ready),
        .prm_valid(prm_valid), .prm_tgt(prm_tgt), .prm_addr(prm_addr), .prm_data(prm_data),
        .prm_ready(prm_ready), .flush(flush),
        .o_valid(o_valid), .o_ready(o_ready), .o_addr(o_addr), .o_data(o_data),
        .err_tgt(err_tgt), .fifo_cnt(fifo_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        o_ready = rdy_rand ? ($urandom_range(0, 99) < 60) : rdy_val;
    end

    // Every packet handed over (valid and ready at the negedge completes on the next posedge).
    always @(negedge clk) begin
        if (o_valid === 1'b1 && o_ready === 1'b1) got.push_back({o_addr, o_data});
    end

    function automatic logic [15:0] pk_pair(input logic [6:0] a, input logic [6:0] b);
        int v;
        v = (int'(a) / 32) * 8192 + (int'(a) % 32) * 128 + int'(b);
        return v[15:0];
    endfunction

    function automatic logic [15:0] pk_rich(input logic [6:0] id);
        int v;
        v = 4096 + int'(id);
        return v[15:0];
    endfunction

    function automatic logic [15:0] pk_param(input logic [1:0] tgt, input logic [6:0] addr);
        int v;
        v = 32768 + int'(tgt) * 8192 + int'(addr);
        return v[15:0];
    endfunction

    // Stream-level model: consecutive non-rich IDs pair up, a rich ID flushes any waiting one as lone.
    function automatic void build_model();
        logic       held;
        logic [6:0] a;
        exp_q.delete();
        held = 1'b0;
        a    = '0;
        foreach (sp_id[i]) begin
            if (sp_rich[i]) begin
                if (held) exp_q.push_back({pk_pair(a, 7'h7F), 32'h0});
                held = 1'b0;
                exp_q.push_back({pk_rich(sp_id[i]), 32'h0});
            end else if (held) begin
                exp_q.push_back({pk_pair(a, sp_id[i]), 32'h0});
                held = 1'b0;
            end else begin
                a    = sp_id[i];
                held = 1'b1;
            end
        end
        if (held) exp_q.push_back({pk_pair(a, 7'h7F), 32'h0});
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_spike(input logic [6:0] id, input logic rich);
        logic ok;
        ok = 1'b0;
        spk_valid = 1'b1;
        spk_id    = id;
        spk_rich  = rich;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (spk_ready) begin
                ok = 1'b1;
                break;
            end
        end
        vec++;
        if (!ok) begin
            bad++;
            $display("FAIL push_timeout: spk_ready=%b required 1 within 300 cycles", spk_ready);
        end
        step();
        spk_valid = 1'b0;
    endtask

    task automatic send_param(input logic [1:0] tgt, input logic [6:0] addr, input logic [31:0] data,
                              output int waited);
        prm_valid = 1'b1;
        prm_tgt   = tgt;
        prm_addr  = addr;
        prm_data  = data;
        waited    = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            waited++;
            if (prm_ready) break;
        end
        step();
        prm_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        prm_valid = 1'b1;
        #2;
        vec++; if (o_valid !== 1'b0)  begin bad++; $display("FAIL rst_o_valid: got %b want 0", o_valid); end
        vec++; if (o_addr !== 16'h0)  begin bad++; $display("FAIL rst_o_addr: got %h want 0000", o_addr); end
        vec++; if (o_data !== 32'h0)  begin bad++; $display("FAIL rst_o_data: got %h want 0", o_data); end
        vec++; if (prm_ready !== 1'b0) begin bad++; $display("FAIL rst_prm_ready: got %b want 0", prm_ready); end
        vec++; if (err_tgt !== 1'b0)  begin bad++; $display("FAIL rst_err_tgt: got %b want 0", err_tgt); end
        vec++; if (fifo_cnt !== '0)   begin bad++; $display("FAIL rst_fifo_cnt: got %0d want 0", fifo_cnt); end
        prm_valid = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        @(negedge clk);
        vec++; if (spk_ready !== 1'b1) begin bad++; $display("FAIL rst_spk_ready: got %b want 1", spk_ready); end
        vec++; if (o_valid !== 1'b0)   begin bad++; $display("FAIL rst_idle_valid: got %b want 0", o_valid); end
        step();
    endtask

    task automatic test_pair();
        int base;
        rdy_val = 1'b1;
        repeat (2) step();
        base = got.size();
        push_spike(7'h25, 1'b0);
        push_spike(7'h13, 1'b0);
        @(negedge clk);
        vec++; if (o_valid !== 1'b0) begin bad++; $display("FAIL pair_early: o_valid=%b want 0", o_valid); end
        @(negedge clk);
        vec++; if (o_valid !== 1'b1) begin bad++; $display("FAIL pair_latency: o_valid=%b want 1", o_valid); end
        repeat (PT + 10) step();
        vec++;
        if (got.size() - base != 1) begin
            bad++; $display("FAIL pair_count: got %0d packets want 1", got.size() - base);
        end else if (got[base] !== {16'h2293, 32'h0}) begin
            bad++; $display("FAIL pair_value: got %h want %h", got[base], {16'h2293, 32'h0});
        end
    endtask

    task automatic test_rich_lone();
        int base;
        int n;
        base = got.size();
        push_spike(7'h05, 1'b1);
        repeat (6) step();
        vec++;
        if (got.size() - base != 1) begin
            bad++; $display("FAIL rich_count: got %0d want 1", got.size() - base);
        end else if (got[base] !== {16'h1005, 32'h0}) begin
            bad++; $display("FAIL rich_value: got %h want %h", got[base], {16'h1005, 32'h0});
        end
        push_spike(7'h41, 1'b0);
        @(negedge clk);
        vec++; if (fifo_cnt !== 1) begin bad++; $display("FAIL pop_lat_stored: fifo_cnt=%0d want 1", fifo_cnt); end
        @(negedge clk);
        vec++; if (fifo_cnt !== 0) begin bad++; $display("FAIL pop_lat_popped: fifo_cnt=%0d want 0", fifo_cnt); end
        n = 0;
        for (int i = 3; i <= PT + 30; i++) begin
            @(negedge clk);
            if (o_valid === 1'b1) begin
                n = i;
                break;
            end
        end
        vec++; if (n != PT + 2) begin bad++; $display("FAIL lone_timeout: valid after %0d cycles want %0d", n, PT + 2); end
        vec++; if (o_addr !== 16'h40FF) begin bad++; $display("FAIL lone_value: got %h want 40ff", o_addr); end
        repeat (4) step();
    endtask

    task automatic test_flush();
        int base;
        base = got.size();
        push_spike(7'h5A, 1'b0);
        repeat (2) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (4) step();
        vec++;
        if (got.size() - base != 1) begin
            bad++; $display("FAIL flush_count: got %0d want 1", got.size() - base);
        end else if (got[base] !== {pk_pair(7'h5A, 7'h7F), 32'h0}) begin
            bad++; $display("FAIL flush_value: got %h want %h", got[base], {pk_pair(7'h5A, 7'h7F), 32'h0});
        end
    endtask

    task automatic test_param();
        int base;
        int w;
        logic [31:0] d1;
        base = got.size();
        d1 = $urandom();
        send_param(2'b11, 7'h7F, d1, w);
        vec++; if (w != 1) begin bad++; $display("FAIL prm_idle_ready: accepted after %0d cycles want 1", w); end
        @(negedge clk);
        vec++; if (o_valid !== 1'b1) begin bad++; $display("FAIL prm_latency: o_valid=%b want 1", o_valid); end
        vec++; if (prm_ready !== 1'b0) begin bad++; $display("FAIL prm_pulse: prm_ready=%b want 0", prm_ready); end
        vec++; if ({o_addr, o_data} !== {pk_param(2'b11, 7'h7F), d1}) begin
            bad++; $display("FAIL prm_value: got %h want %h", {o_addr, o_data}, {pk_param(2'b11, 7'h7F), d1});
        end
        repeat (3) step();
        push_spike(7'h33, 1'b0);
        repeat (3) step();
        send_param(2'b01, 7'h0A, 32'hDEADBEEF, w);
        vec++; if (w != 1) begin bad++; $display("FAIL prm_hold_ready: accepted after %0d cycles want 1", w); end
        push_spike(7'h22, 1'b0);
        repeat (8) step();
        vec++;
        if (got.size() - base != 3) begin
            bad++; $display("FAIL prm_count: got %0d want 3", got.size() - base);
        end else begin
            if (got[base + 1] !== {16'hA00A, 32'hDEADBEEF}) begin
                bad++; $display("FAIL prm_first: got %h want a00adeadbeef", got[base + 1]);
            end
            vec++;
            if (got[base + 2] !== {pk_pair(7'h33, 7'h22), 32'h0}) begin
                bad++; $display("FAIL prm_then_pair: got %h want %h", got[base + 2], {pk_pair(7'h33, 7'h22), 32'h0});
            end
        end
    endtask

    task automatic test_illegal();
        int base;
        int w;
        base = got.size();
        send_param(2'b00, 7'h11, 32'h1234_5678, w);
        vec++; if (w != 1) begin bad++; $display("FAIL ill_ready: accepted after %0d cycles want 1", w); end
        @(negedge clk);
        vec++; if (err_tgt !== 1'b1) begin bad++; $display("FAIL ill_err: err_tgt=%b want 1", err_tgt); end
        vec++; if (o_valid !== 1'b0) begin bad++; $display("FAIL ill_valid: o_valid=%b want 0", o_valid); end
        step();
        push_spike(7'h7F, 1'b0);
        @(negedge clk);
        vec++; if (fifo_cnt !== 0) begin bad++; $display("FAIL null_cnt: fifo_cnt=%0d want 0", fifo_cnt); end
        repeat (PT + 8) step();
        vec++; if (got.size() != base) begin bad++; $display("FAIL ill_nopkt: got %0d packets want 0", got.size() - base); end
        vec++; if (err_tgt !== 1'b1) begin bad++; $display("FAIL ill_sticky: err_tgt=%b want 1", err_tgt); end
    endtask

    task automatic test_fill();
        int base;
        logic [6:0]  id;
        logic [47:0] snap;
        rdy_val = 1'b0;
        repeat (2) step();
        base = got.size();
        sp_id.delete();
        sp_rich.delete();
        for (int i = 0; i < DEPTH + 2; i++) begin
            id = 7'($urandom_range(0, 126));
            sp_id.push_back(id);
            sp_rich.push_back(1'b0);
            push_spike(id, 1'b0);
        end
        @(negedge clk);
        vec++; if (spk_ready !== 1'b0) begin bad++; $display("FAIL full_ready: spk_ready=%b want 0", spk_ready); end
        vec++; if (fifo_cnt !== DEPTH) begin bad++; $display("FAIL full_cnt: fifo_cnt=%0d want %0d", fifo_cnt, DEPTH); end
        vec++; if (o_valid !== 1'b1) begin bad++; $display("FAIL full_valid: o_valid=%b want 1", o_valid); end
        snap = {o_addr, o_data};
        vec++; if (snap !== {pk_pair(sp_id[0], sp_id[1]), 32'h0}) begin
            bad++; $display("FAIL full_head: got %h want %h", snap, {pk_pair(sp_id[0], sp_id[1]), 32'h0});
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            vec++;
            if ({o_addr, o_data} !== snap) begin
                bad++; $display("FAIL hold_stable: got %h want %h", {o_addr, o_data}, snap);
            end
        end
        build_model();
        step();
        rdy_rand = 1'b1;
        for (int i = 0; i < 3000 && got.size() < base + exp_q.size(); i++) step();
        repeat (PT + 10) step();
        vec++;
        if (got.size() - base != exp_q.size()) begin
            bad++; $display("FAIL drain_count: got %0d want %0d", got.size() - base, exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (base + i < got.size()) begin
                vec++;
                if (got[base + i] !== exp_q[i]) begin
                    bad++; $display("FAIL drain_order[%0d]: got %h want %h", i, got[base + i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        int base;
        logic [6:0] id;
        logic       rich;
        logic       last_null;
        rdy_rand = 1'b1;
        base = got.size();
        sp_id.delete();
        sp_rich.delete();
        last_null = 1'b0;
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 2)) step();
            id   = 7'($urandom_range(0, 126));
            rich = ($urandom_range(0, 3) == 0);
            if (!last_null && $urandom_range(0, 9) == 0) id = 7'h7F;
            last_null = (id == 7'h7F);
            push_spike(id, rich);
            if (id != 7'h7F) begin
                sp_id.push_back(id);
                sp_rich.push_back(rich);
            end
        end
        build_model();
        for (int i = 0; i < 4000 && got.size() < base + exp_q.size(); i++) step();
        repeat (PT + 10) step();
        vec++;
        if (got.size() - base != exp_q.size()) begin
            bad++; $display("FAIL rand_count: got %0d want %0d", got.size() - base, exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (base + i < got.size()) begin
                vec++;
                if (got[base + i] !== exp_q[i]) begin
                    bad++; $display("FAIL rand_pkt[%0d]: got %h want %h", i, got[base + i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int base;
        rdy_rand = 1'b0;
        rdy_val  = 1'b0;
        repeat (2) step();
        for (int i = 0; i < 5; i++) push_spike(7'(10 + i), 1'b0);
        @(negedge clk);
        vec++; if (fifo_cnt !== 3) begin bad++; $display("FAIL mid_cnt: fifo_cnt=%0d want 3", fifo_cnt); end
        vec++; if (o_valid !== 1'b1) begin bad++; $display("FAIL mid_valid: o_valid=%b want 1", o_valid); end
        #2 rst = 1'b0;
        #1;
        vec++; if (o_valid !== 1'b0) begin bad++; $display("FAIL arst_valid: o_valid=%b want 0", o_valid); end
        vec++; if (fifo_cnt !== 0)   begin bad++; $display("FAIL arst_cnt: fifo_cnt=%0d want 0", fifo_cnt); end
        vec++; if (o_addr !== 16'h0) begin bad++; $display("FAIL arst_addr: o_addr=%h want 0000", o_addr); end
        base = got.size();
        step();
        rdy_val = 1'b1;
        step();
        rst = 1'b1;
        repeat (PT + 24) step();
        vec++; if (got.size() != base) begin bad++; $display("FAIL post_rst_pkt: got %0d packets want 0", got.size() - base); end
        vec++; if (o_valid !== 1'b0) begin bad++; $display("FAIL post_rst_valid: o_valid=%b want 0", o_valid); end
        vec++; if (err_tgt !== 1'b0) begin bad++; $display("FAIL post_rst_err: err_tgt=%b want 0", err_tgt); end
    endtask

    initial begin
        test_reset();
        test_pair();
        test_rich_lone();
        test_flush();
        test_param();
        test_illegal();
        test_fill();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
